// File: rtl/sap_pkg.sv
// Shared definitions for the SAP control sequencer: opcode values, control-word
// bit positions and the per-opcode last execute step.
package sap_pkg;

    localparam int OP_NOP = 0;
    localparam int OP_LDA = 1;
    localparam int OP_ADD = 2;
    localparam int OP_SUB = 3;
    localparam int OP_STA = 4;
    localparam int OP_LDI = 5;
    localparam int OP_JMP = 6;
    localparam int OP_JC  = 7;
    localparam int OP_JZ  = 8;
    localparam int OP_OUT = 14;
    localparam int OP_HLT = 15;

    localparam int CW_PCOE     = 0;
    localparam int CW_PCJMP    = 1;
    localparam int CW_PCINC    = 2;
    localparam int CW_MARWA    = 3;
    localparam int CW_RAMOA    = 4;
    localparam int CW_RAMWA    = 5;
    localparam int CW_INREGWA  = 6;
    localparam int CW_INREGOA  = 7;
    localparam int CW_AWA      = 8;
    localparam int CW_AOA      = 9;
    localparam int CW_BWA      = 10;
    localparam int CW_BOA      = 11;
    localparam int CW_SUMOUT   = 12;
    localparam int CW_SUB      = 13;
    localparam int CW_FLAGSIN  = 14;
    localparam int CW_OUTREGWA = 15;
    localparam int CW_W        = 16;

    // The opcode only becomes valid at T2, so every instruction, including an
    // empty one, is decided no earlier than T2.
    function automatic int unsigned last_step(input int unsigned op);
        case (op)
            OP_LDA, OP_STA: return 3;
            OP_ADD, OP_SUB: return 4;
            default:        return 2;
        endcase
    endfunction

endpackage

// File: rtl/sap_tstate_counter.sv
// T-state counter with run gating, early instruction end, wrap and sticky halt.
module sap_tstate_counter #(
    parameter int TSTATES   = 6,
    parameter int EARLY_END = 1,
    parameter int TSW       = $clog2(TSTATES)
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           run,
    input  logic           step_last,
    input  logic           hlt_step,
    output logic [TSW-1:0] tstate,
    output logic           halted
);

    logic [TSW-1:0] tstate_q, tstate_d;
    logic           halted_q, halted_d;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            tstate_q <= '0;
            halted_q <= 1'b0;
        end else begin
            tstate_q <= tstate_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        tstate_d = tstate_q;
        halted_d = halted_q;
        if (halted_q) begin
            tstate_d = '0;
        end else if ((tstate_q == '0) && !run) begin
            tstate_d = '0;
        end else if (hlt_step) begin
            halted_d = 1'b1;
            tstate_d = '0;
        end else if ((EARLY_END != 0) && step_last) begin
            tstate_d = '0;
        end else if (tstate_q == TSW'(TSTATES - 1)) begin
            tstate_d = '0;
        end else begin
            tstate_d = tstate_q + TSW'(1);
        end
    end

    assign tstate = tstate_q;
    assign halted = halted_q;

endmodule

// File: rtl/sap_control_seq.sv
// Microcoded control sequencer for the 8-bit bus computer: decodes
// (opcode, T-state, flags) into the datapath control word.
module sap_control_seq
    import sap_pkg::*;
#(
    parameter int OPW       = 4,
    parameter int TSTATES   = 6,
    parameter int EARLY_END = 1
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       run,
    input  logic [OPW-1:0]             opcode,
    input  logic                       cf,
    input  logic                       zf,
    output logic                       pcoe,
    output logic                       pcjmp,
    output logic                       pcinc,
    output logic                       marwa,
    output logic                       ramoa,
    output logic                       ramwa,
    output logic                       inregwa,
    output logic                       inregoa,
    output logic                       awa,
    output logic                       aoa,
    output logic                       bwa,
    output logic                       boa,
    output logic                       sumout,
    output logic                       sub,
    output logic                       flagsin,
    output logic                       outregwa,
    output logic                       halted,
    output logic [$clog2(TSTATES)-1:0] tstate
);

    localparam int TSW = $clog2(TSTATES);

    logic [TSW-1:0]  tstate_q;
    logic            halted_q;
    logic            step_last;
    logic            hlt_step;
    logic [CW_W-1:0] cw;

    sap_tstate_counter #(
        .TSTATES   (TSTATES),
        .EARLY_END (EARLY_END),
        .TSW       (TSW)
    ) u_counter (
        .clk       (clk),
        .clr       (clr),
        .run       (run),
        .step_last (step_last),
        .hlt_step  (hlt_step),
        .tstate    (tstate_q),
        .halted    (halted_q)
    );

    // Instruction length depends on the opcode only, never on cf/zf.
    assign step_last = (tstate_q >= TSW'(2)) &&
                       (32'(tstate_q) == last_step(32'(opcode)));
    assign hlt_step  = (opcode == OPW'(OP_HLT)) && (tstate_q == TSW'(2));

    always_comb begin
        cw = '0;
        if (tstate_q == '0) begin
            cw[CW_PCOE]  = run;
            cw[CW_MARWA] = run;
        end else if (tstate_q == TSW'(1)) begin
            cw[CW_RAMOA]   = 1'b1;
            cw[CW_INREGWA] = 1'b1;
            cw[CW_PCINC]   = 1'b1;
        end else begin
            case ({opcode, tstate_q})
                {OPW'(OP_LDA), TSW'(2)},
                {OPW'(OP_ADD), TSW'(2)},
                {OPW'(OP_SUB), TSW'(2)},
                {OPW'(OP_STA), TSW'(2)}: begin
                    cw[CW_INREGOA] = 1'b1;
                    cw[CW_MARWA]   = 1'b1;
                end
                {OPW'(OP_LDA), TSW'(3)}: begin
                    cw[CW_RAMOA] = 1'b1;
                    cw[CW_AWA]   = 1'b1;
                end
                {OPW'(OP_ADD), TSW'(3)},
                {OPW'(OP_SUB), TSW'(3)}: begin
                    cw[CW_RAMOA] = 1'b1;
                    cw[CW_BWA]   = 1'b1;
                end
                {OPW'(OP_ADD), TSW'(4)},
                {OPW'(OP_SUB), TSW'(4)}: begin
                    cw[CW_SUMOUT]  = 1'b1;
                    cw[CW_AWA]     = 1'b1;
                    cw[CW_FLAGSIN] = 1'b1;
                    cw[CW_SUB]     = (opcode == OPW'(OP_SUB));
                end
                {OPW'(OP_STA), TSW'(3)}: begin
                    cw[CW_AOA]   = 1'b1;
                    cw[CW_RAMWA] = 1'b1;
                end
                {OPW'(OP_LDI), TSW'(2)}: begin
                    cw[CW_INREGOA] = 1'b1;
                    cw[CW_AWA]     = 1'b1;
                end
                {OPW'(OP_JMP), TSW'(2)}: begin
                    cw[CW_INREGOA] = 1'b1;
                    cw[CW_PCJMP]   = 1'b1;
                end
                {OPW'(OP_JC), TSW'(2)}: begin
                    cw[CW_INREGOA] = 1'b1;
                    cw[CW_PCJMP]   = cf;
                end
                {OPW'(OP_JZ), TSW'(2)}: begin
                    cw[CW_INREGOA] = 1'b1;
                    cw[CW_PCJMP]   = zf;
                end
                {OPW'(OP_OUT), TSW'(2)}: begin
                    cw[CW_AOA]      = 1'b1;
                    cw[CW_OUTREGWA] = 1'b1;
                end
                default: ;
            endcase
        end
        // clr gates the outputs directly so they drop before any clock edge.
        if (!clr || halted_q) begin
            cw = '0;
        end
    end

    assign pcoe     = cw[CW_PCOE];
    assign pcjmp    = cw[CW_PCJMP];
    assign pcinc    = cw[CW_PCINC];
    assign marwa    = cw[CW_MARWA];
    assign ramoa    = cw[CW_RAMOA];
    assign ramwa    = cw[CW_RAMWA];
    assign inregwa  = cw[CW_INREGWA];
    assign inregoa  = cw[CW_INREGOA];
    assign awa      = cw[CW_AWA];
    assign aoa      = cw[CW_AOA];
    assign bwa      = cw[CW_BWA];
    assign boa      = cw[CW_BOA];
    assign sumout   = cw[CW_SUMOUT];
    assign sub      = cw[CW_SUB];
    assign flagsin  = cw[CW_FLAGSIN];
    assign outregwa = cw[CW_OUTREGWA];
    assign halted   = halted_q;
    assign tstate   = tstate_q;

endmodule
